// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Brief    : IF stage - PC register, word-organised instruction memory with a
//            load port, and a count of advancing/redirecting cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int          IMEM_BYTES = 256,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] Instruction,
  output logic [63:0] PC_Out,
  output logic [63:0] fetch_count
);

  localparam int          c_WORDS    = IMEM_BYTES / 4;
  localparam int          c_AW       = $clog2(c_WORDS);
  localparam logic [63:0] c_BYTES    = 64'(IMEM_BYTES);
  localparam logic [63:0] c_RESET_PC = {RESET_PC[63:2], 2'b00};
  localparam logic [31:0] c_NOP      = 32'h0000_0013;

  logic [31:0] r_mem [c_WORDS];
  logic [63:0] r_pc;
  logic [63:0] r_fetch_count;

  logic        w_waddr_in_range;
  logic        w_pc_in_range;
  logic        w_pc_moves;

  assign w_waddr_in_range = (imem_waddr < c_BYTES);
  assign w_pc_in_range    = (r_pc < c_BYTES);
  assign w_pc_moves       = redirect || !stall;

  // Memory has no reset so the loader can fill it while the core is held.
  always_ff @(posedge clk) begin
    if (imem_we && w_waddr_in_range) begin
      r_mem[imem_waddr[c_AW+1:2]] <= imem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= c_RESET_PC;
      r_fetch_count <= 64'd0;
    end else begin
      if (redirect) begin
        r_pc <= {redirect_target[63:2], 2'b00};
      end else if (!stall) begin
        r_pc <= r_pc + 64'd4;
      end
      if (w_pc_moves) begin
        r_fetch_count <= r_fetch_count + 64'd1;
      end
    end
  end

  // Addresses beyond the array return a NOP instead of aliasing into it.
  assign Instruction = w_pc_in_range ? r_mem[r_pc[c_AW+1:2]] : c_NOP;
  assign PC_Out      = r_pc;
  assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench for instruction_fetch against a behavioural
//            model of PC, fetch count and memory contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  localparam int          IMEM_BYTES = 256;
  localparam int          c_WORDS    = IMEM_BYTES / 4;
  localparam logic [31:0] c_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = 64'd0;
  logic        imem_we = 1'b0;
  logic [63:0] imem_waddr = 64'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic [31:0] Instruction;
  logic [63:0] PC_Out;
  logic [63:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [63:0] m_pc  = 64'd0;
  logic [63:0] m_cnt = 64'd0;
  logic [31:0] m_mem [c_WORDS];

  instruction_fetch #(
    .IMEM_BYTES(IMEM_BYTES),
    .RESET_PC  (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .Instruction    (Instruction),
    .PC_Out         (PC_Out),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_instr();
    if (m_pc < 64'(IMEM_BYTES)) return m_mem[int'(m_pc / 64'd4)];
    return c_NOP;
  endfunction

  // Drive one cycle of inputs, apply the edge to the model, return at edge+1.
  task automatic step(input logic st, input logic rd, input logic [63:0] tgt,
                      input logic we, input logic [63:0] wa, input logic [31:0] wd);
    stall = st; redirect = rd; redirect_target = tgt;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    if (we && wa < 64'(IMEM_BYTES)) m_mem[int'(wa / 64'd4)] = wd;
    if (!reset) begin
      if (rd || !st) m_cnt = m_cnt + 64'd1;
      if (rd) m_pc = tgt & ~64'h3;
      else if (!st) m_pc = m_pc + 64'd4;
    end
    #1;
    stall = 1'b0; redirect = 1'b0; imem_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] prog [4];
    prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
    // Fill memory while reset is held
    for (int i = 0; i < c_WORDS; i++)
      step(1'b0, 1'b0, 64'd0, 1'b1, 64'(i * 4), (i < 4) ? prog[i] : $urandom);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 64'd0; m_cnt = 64'd0;
    #1;
    n_checks++; if (PC_Out !== 64'd0) $display("FAIL reset_pc: got %h want %h", PC_Out, 64'd0); else n_pass++;
    n_checks++; if (fetch_count !== 64'd0) $display("FAIL reset_count: got %h want 0", fetch_count); else n_pass++;
    n_checks++; if (Instruction !== 32'h00500093) $display("FAIL reset_instr: got %h want 00500093", Instruction); else n_pass++;
  endtask

  task automatic test_sequencing();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h00500093; exp_i[1] = 32'h00A00113;
    exp_i[2] = 32'h002081B3; exp_i[3] = 32'h00000013;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (PC_Out !== 64'(i * 4)) $display("FAIL seq_pc%0d: got %h want %h", i, PC_Out, 64'(i * 4)); else n_pass++;
      n_checks++; if (Instruction !== exp_i[i]) $display("FAIL seq_instr%0d: got %h want %h", i, Instruction, exp_i[i]); else n_pass++;
      step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
    end
    n_checks++; if (fetch_count !== 64'd4) $display("FAIL seq_count: got %0d want 4", fetch_count); else n_pass++;
    n_checks++; if (PC_Out !== 64'd16) $display("FAIL seq_pc_end: got %h want 10", PC_Out); else n_pass++;
  endtask

  task automatic test_stall();
    logic [63:0] c0;
    step(1'b0, 1'b1, 64'd8, 1'b0, 64'd0, 32'd0);
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
      n_checks++; if (PC_Out !== 64'd8) $display("FAIL stall_pc%0d: got %h want 8", i, PC_Out); else n_pass++;
      n_checks++; if (Instruction !== 32'h002081B3) $display("FAIL stall_instr%0d: got %h want 002081b3", i, Instruction); else n_pass++;
      n_checks++; if (fetch_count !== c0) $display("FAIL stall_count%0d: got %0d want %0d", i, fetch_count, c0); else n_pass++;
    end
    step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
    n_checks++; if (PC_Out !== 64'd12) $display("FAIL stall_resume_pc: got %h want c", PC_Out); else n_pass++;
    n_checks++; if (fetch_count !== c0 + 64'd1) $display("FAIL stall_resume_count: got %0d want %0d", fetch_count, c0 + 64'd1); else n_pass++;
  endtask

  task automatic test_redirect_priority();
    logic [63:0] c0;
    c0 = m_cnt;
    step(1'b1, 1'b1, 64'h16, 1'b0, 64'd0, 32'd0);
    n_checks++; if (PC_Out !== 64'h14) $display("FAIL redir_pc: got %h want 14", PC_Out); else n_pass++;
    n_checks++; if (fetch_count !== c0 + 64'd1) $display("FAIL redir_count: got %0d want %0d", fetch_count, c0 + 64'd1); else n_pass++;
    n_checks++; if (Instruction !== m_instr()) $display("FAIL redir_instr: got %h want %h", Instruction, m_instr()); else n_pass++;
  endtask

  task automatic test_out_of_range();
    step(1'b0, 1'b1, 64'd256, 1'b0, 64'd0, 32'd0);
    n_checks++; if (PC_Out !== 64'd256) $display("FAIL oor_pc: got %h want 100", PC_Out); else n_pass++;
    n_checks++; if (Instruction !== c_NOP) $display("FAIL oor_instr: got %h want 00000013", Instruction); else n_pass++;
    step(1'b1, 1'b0, 64'd0, 1'b1, 64'd256, 32'hA5A5_5A5A);
    step(1'b1, 1'b0, 64'd0, 1'b1, 64'h1_0000_0000, 32'h1234_5678);
    // Sweep every word to confirm nothing aliased in
    for (int i = 0; i < c_WORDS; i++) begin
      step(1'b0, 1'b1, 64'(i * 4), 1'b0, 64'd0, 32'd0);
      n_checks++; if (Instruction !== m_mem[i]) $display("FAIL oor_mem%0d: got %h want %h", i, Instruction, m_mem[i]); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    m_pc = 64'd0; m_cnt = 64'd0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
    step(1'b0, 1'b1, 64'h40, 1'b0, 64'd0, 32'd0);
    n_checks++; if (PC_Out !== 64'h40 || fetch_count !== 64'd17) $display("FAIL arst_pre: got pc %h cnt %0d want 40/17", PC_Out, fetch_count); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (PC_Out !== 64'd0) $display("FAIL arst_pc: got %h want 0", PC_Out); else n_pass++;
    n_checks++; if (fetch_count !== 64'd0) $display("FAIL arst_count: got %0d want 0", fetch_count); else n_pass++;
    m_pc = 64'd0; m_cnt = 64'd0;
    step(1'b0, 1'b1, 64'h80, 1'b0, 64'd0, 32'd0);
    n_checks++; if (PC_Out !== 64'd0 || fetch_count !== 64'd0) $display("FAIL arst_hold: got pc %h cnt %0d want 0/0", PC_Out, fetch_count); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (Instruction !== m_mem[0]) $display("FAIL arst_mem: got %h want %h", Instruction, m_mem[0]); else n_pass++;
  endtask

  task automatic test_wrap_and_collision();
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 32'd0);
    n_checks++; if (PC_Out !== 64'hFFFF_FFFF_FFFF_FFFC || Instruction !== c_NOP) $display("FAIL wrap_top: got pc %h instr %h want fffffffffffffffc/00000013", PC_Out, Instruction); else n_pass++;
    step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 32'd0);
    n_checks++; if (PC_Out !== 64'd0) $display("FAIL wrap_pc: got %h want 0", PC_Out); else n_pass++;
    step(1'b0, 1'b1, 64'h24, 1'b0, 64'd0, 32'd0);
    // Write the held word; old contents must persist until the edge
    stall = 1'b1; imem_we = 1'b1; imem_waddr = 64'h24; imem_wdata = 32'hDEADBEEF;
    #2;
    n_checks++; if (Instruction !== m_mem[9]) $display("FAIL coll_before: got %h want %h", Instruction, m_mem[9]); else n_pass++;
    step(1'b1, 1'b0, 64'd0, 1'b1, 64'h24, 32'hDEADBEEF);
    n_checks++; if (Instruction !== 32'hDEADBEEF) $display("FAIL coll_after: got %h want deadbeef", Instruction); else n_pass++;
    n_checks++; if (PC_Out !== 64'h24) $display("FAIL coll_pc: got %h want 24", PC_Out); else n_pass++;
  endtask

  task automatic test_random();
    logic        st, rd, we;
    logic [63:0] tgt, wa;
    int          errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 300));
      we  = ($urandom_range(0, 2) == 0);
      wa  = ($urandom_range(0, 7) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 300));
      step(st, rd, tgt, we, wa, $urandom);
      n_checks++;
      if (PC_Out !== m_pc || fetch_count !== m_cnt || Instruction !== m_instr()) begin
        if (errs < 10)
          $display("FAIL rand%0d: got pc %h cnt %0d instr %h want pc %h cnt %0d instr %h",
                   i, PC_Out, fetch_count, Instruction, m_pc, m_cnt, m_instr());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_sequencing();
    test_stall();
    test_redirect_priority();
    test_out_of_range();
    test_async_reset();
    test_wrap_and_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the pipelined 64-bit RISC-V core. It holds the program counter and a word-organised, byte-addressed instruction memory, and presents the current instruction and its PC to the IF/ID pipeline register every cycle. It sits directly upstream of IF/ID. It takes stall and branch-redirect controls from the hazard and branch logic, and exposes a load port for filling instruction memory.

## Interface
Parameters:
- IMEM_BYTES, 256: instruction memory size in bytes. Power of two, ≥8. Holds IMEM_BYTES/4 words.
- RESET_PC, 64'h0: PC value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- stall  input  1  hold PC this cycle.
- redirect  input  1  load PC from redirect_target this cycle.
- redirect_target  input  64  branch/jump target byte address.
- imem_we  input  1  instruction memory word write enable.
- imem_waddr  input  64  byte address of the word to write; bits [1:0] ignored.
- imem_wdata  input  32  instruction word to write.
- Instruction  output  32  instruction at PC_Out (combinational read); feeds IF/ID Instruction.
- PC_Out  output  64  current PC; feeds IF/ID PC_Out.
- fetch_count  output  64  number of cycles in which the PC advanced or was redirected.

## Operation
- PC register update, in priority order:
  - reset → RESET_PC with bits [1:0] cleared.
  - redirect → {redirect_target[63:2], 2'b00}. Overrides stall.
  - stall → hold.
  - otherwise → PC + 4, modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Instruction read:
  - When PC_Out < IMEM_BYTES: Instruction = mem[PC_Out >> 2], combinational.
  - When PC_Out ≥ IMEM_BYTES: Instruction = 32'h0000_0013 (addi x0,x0,0 NOP). No aliasing.
- Memory write:
  - When imem_we=1 and imem_waddr < IMEM_BYTES, mem[imem_waddr >> 2] ← imem_wdata at the rising edge.
  - Out-of-range writes are dropped silently.
  - Writes are allowed at any time, including during reset.
- Memory contents are not cleared by reset. Contents before the first write are undefined; the bench loads memory first.
- fetch_count:
  - Reset → 0.
  - Increments by 1 on each edge where redirect=1, or where stall=0 and not in reset.
  - Wraps modulo 2^64.
- PC_Out equals the PC register.

## Timing
- Reset values: PC_Out = RESET_PC & ~64'h3; fetch_count = 0. Instruction follows memory at that address.
- Reset asserted mid-run forces PC_Out and fetch_count to their reset values immediately, without waiting for an edge. Redirect and stall are ignored while reset=1.
- First edge after reset deasserts with no stall/redirect: PC_Out = RESET_PC + 4.
- Redirect latency: target visible on PC_Out one cycle after the edge sampling redirect=1. The redirect_target instruction appears on Instruction in the same cycle.
- Stall: PC_Out and Instruction are held for every cycle stall=1 (unless that memory word is written).
- Write/read collision: a write to the word at PC_Out leaves Instruction at the old value until the edge, and the new value appears after it.
- Simultaneous redirect and stall: redirect wins, and fetch_count increments.
- Instruction is combinational from PC_Out and memory. IF/ID captures the pair on the same edge that the PC advances.

## Test plan
- Reset/sequencing:
  - Stimulus: load words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013. RESET_PC=0. Release reset.
  - Required: over 4 edges, PC_Out = 0, 4, 8, 12 with the matching Instruction each cycle; fetch_count = 4.
- Stall:
  - Stimulus: assert stall for 3 cycles at PC_Out=8.
  - Required: PC_Out stays 8 and Instruction stays 32'h002081B3. fetch_count is unchanged, then resumes to 12.
- Redirect priority:
  - Stimulus: redirect=1, stall=1, redirect_target=64'h16.
  - Required: next PC_Out = 64'h14, and fetch_count increments.
- Out-of-range:
  - Stimulus: redirect_target = IMEM_BYTES (256).
  - Required: PC_Out = 256, Instruction = 32'h00000013. A write to imem_waddr=256 leaves all memory unchanged.
- Async reset mid-run:
  - Stimulus: assert reset between edges while PC_Out=64'h40, fetch_count=17.
  - Required: both outputs go to 0 before the next edge, and memory contents are retained.
- Wrap and collision:
  - Stimulus: redirect to 64'hFFFF_FFFF_FFFF_FFFC, then advance. Separately, write 32'hDEADBEEF to the word at the held (stalled) PC.
  - Required: PC_Out wraps to 0. Instruction changes to 32'hDEADBEEF only after the write edge.
